seg7_monitor: RTL and testbench



---
 rtl/seg7_monitor.sv | 178 +++++++++++++++++
 tb/tb_seg7_monitor.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_monitor.sv
// Seven-segment bus monitor: glitch filter, segment decode and valid/ready update reporting.
// Optional single-digit +1 step checking is enabled by defining SEG7_MONITOR_STEP_CHECK_EN.
module seg7_monitor #(
   parameter int NUM_DIGITS    = 8,
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [7*NUM_DIGITS-1:0] hex,
   output logic [4*NUM_DIGITS-1:0] digits,
   output logic [NUM_DIGITS-1:0]   blank,
   output logic                    upd_valid,
   input  logic                    upd_ready,
   output logic                    overrun,
   output logic                    bad_pat,
   output logic                    step_err,
   output logic [CNT_W-1:0]        upd_cnt
);

   localparam int              HW        = 7 * NUM_DIGITS;
   localparam logic [7:0]      CNT_MAX   = 8'(STABLE_CYCLES - 1);
   localparam logic [HW-1:0]   ALL_BLANK = {NUM_DIGITS{7'h7F}};

   typedef enum logic {IDLE, PEND} state_t;

   // Returns {hit, digit}; the blank pattern is not a hit.
   function automatic logic [4:0] seg_decode(input logic [6:0] p);
      case (p)
         7'h40: seg_decode = 5'h10;
         7'h79: seg_decode = 5'h11;
         7'h24: seg_decode = 5'h12;
         7'h30: seg_decode = 5'h13;
         7'h19: seg_decode = 5'h14;
         7'h12: seg_decode = 5'h15;
         7'h02: seg_decode = 5'h16;
         7'h78: seg_decode = 5'h17;
         7'h00: seg_decode = 5'h18;
         7'h10: seg_decode = 5'h19;
         7'h08: seg_decode = 5'h1A;
         7'h03: seg_decode = 5'h1B;
         7'h46: seg_decode = 5'h1C;
         7'h21: seg_decode = 5'h1D;
         7'h06: seg_decode = 5'h1E;
         7'h0E: seg_decode = 5'h1F;
         default: seg_decode = 5'h00;
      endcase
   endfunction

   logic [HW-1:0]           hex_q, hex_d, cand_q, cand_d, acc_q, acc_d;
   logic [7:0]              cnt_q, cnt_d;
   logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
   logic [NUM_DIGITS-1:0]   blank_q, blank_d;
   state_t                  state_q, state_d;
   logic                    overrun_q, overrun_d, bad_q, bad_d;
   logic [CNT_W-1:0]        upd_cnt_q, upd_cnt_d;
   logic                    accept;

   logic [4*NUM_DIGITS-1:0] new_digit;
   logic [NUM_DIGITS-1:0]   new_hit, new_blank;

   for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dec
      logic [4:0] d;
      assign d                = seg_decode(cand_q[7*k +: 7]);
      assign new_hit[k]       = d[4];
      assign new_digit[4*k +: 4] = d[3:0];
      assign new_blank[k]     = (cand_q[7*k +: 7] == 7'h7F);
   end

   always_comb begin
      hex_d     = hex;
      cand_d    = cand_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      digits_d  = digits_q;
      blank_d   = blank_q;
      state_d   = state_q;
      overrun_d = overrun_q;
      bad_d     = bad_q;
      upd_cnt_d = upd_cnt_q;
      accept    = (cnt_q == CNT_MAX) && (cand_q != acc_q);

      if (hex_q != cand_q) begin
         cand_d = hex_q;
         cnt_d  = 8'd0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + 8'd1;
      end

      case (state_q)
         IDLE: if (accept) state_d = PEND;
         PEND: begin
            if (accept && !upd_ready)      overrun_d = 1'b1;
            else if (!accept && upd_ready) state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (accept) begin
         acc_d     = cand_q;
         digits_d  = new_digit;
         blank_d   = new_blank;
         upd_cnt_d = upd_cnt_q + 1'b1;
         if ((~new_hit & ~new_blank) != '0) bad_d = 1'b1;
      end
   end

   // Sample path resets to the blank bus so an idle display never looks like a change.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hex_q     <= ALL_BLANK;
         cand_q    <= ALL_BLANK;
         cnt_q     <= 8'd0;
         acc_q     <= ALL_BLANK;
         digits_q  <= '0;
         blank_q   <= '1;
         state_q   <= IDLE;
         overrun_q <= 1'b0;
         bad_q     <= 1'b0;
         upd_cnt_q <= '0;
      end else begin
         hex_q     <= hex_d;
         cand_q    <= cand_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         digits_q  <= digits_d;
         blank_q   <= blank_d;
         state_q   <= state_d;
         overrun_q <= overrun_d;
         bad_q     <= bad_d;
         upd_cnt_q <= upd_cnt_d;
      end
   end

`ifdef SEG7_MONITOR_STEP_CHECK_EN
   logic [NUM_DIGITS-1:0] grp_diff, grp_ok;
   logic                  step_ok, seen_q, seen_d, step_q, step_d;

   for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_step
      logic [4:0] o;
      assign o           = seg_decode(acc_q[7*k +: 7]);
      assign grp_diff[k] = (acc_q[7*k +: 7] != cand_q[7*k +: 7]);
      assign grp_ok[k]   = o[4] && new_hit[k] && (new_digit[4*k +: 4] == 4'(o[3:0] + 4'd1));
   end

   always_comb begin
      seen_d  = seen_q;
      step_d  = step_q;
      step_ok = $onehot(grp_diff) && ((grp_diff & ~grp_ok) == '0);
      if (accept) begin
         seen_d = 1'b1;
         if (seen_q && !step_ok) step_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         seen_q <= 1'b0;
         step_q <= 1'b0;
      end else begin
         seen_q <= seen_d;
         step_q <= step_d;
      end
   end

   assign step_err = step_q;
`else
   assign step_err = 1'b0;
`endif

   assign digits    = digits_q;
   assign blank     = blank_q;
   assign upd_valid = (state_q == PEND);
   assign overrun   = overrun_q;
   assign bad_pat   = bad_q;
   assign upd_cnt   = upd_cnt_q;

endmodule

// File: tb/tb_seg7_monitor.sv
// Bench for seg7_monitor: directed scenarios plus random bus traffic against a sample-history model.
module tb_seg7_monitor;
   localparam int N  = 8;
   localparam int S  = 4;
   localparam int CW = 16;
`ifdef SEG7_MONITOR_STEP_CHECK_EN
   localparam logic STEP_EN = 1'b1;
`else
   localparam logic STEP_EN = 1'b0;
`endif
   localparam logic [7*N-1:0] ALLB = {N{7'h7F}};
   localparam logic [6:0] TBL [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                       7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   logic clk = 1'b0, rst_n = 1'b0, upd_ready = 1'b0;
   logic [7*N-1:0] hex = ALLB;
   logic [4*N-1:0] digits;
   logic [N-1:0]   blank;
   logic           upd_valid, overrun, bad_pat, step_err;
   logic [CW-1:0]  upd_cnt;
   int total = 0, bad = 0;

   seg7_monitor #(.NUM_DIGITS(N), .STABLE_CYCLES(S), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .hex(hex), .digits(digits), .blank(blank),
      .upd_valid(upd_valid), .upd_ready(upd_ready), .overrun(overrun),
      .bad_pat(bad_pat), .step_err(step_err), .upd_cnt(upd_cnt));

   always #5 clk = ~clk;

   // Reference: an update fires when the last S bus samples (ending two edges back) agree
   // and differ from the last accepted bus value.
   logic [4*N-1:0] m_digits;
   logic [N-1:0]   m_blank;
   logic           m_valid, m_over, m_bad, m_step, m_first;
   logic [CW-1:0]  m_cnt;
   logic [7*N-1:0] m_acc;
   logic [7*N-1:0] samp[$];

   function automatic void mdec(input logic [6:0] p, output logic hit, output logic [3:0] d);
      hit = 1'b0; d = 4'd0;
      for (int i = 0; i < 16; i++) if (TBL[i] == p) begin hit = 1'b1; d = 4'(i); end
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         m_digits = '0; m_blank = '1; m_valid = 0; m_over = 0; m_bad = 0; m_step = 0;
         m_cnt = '0; m_acc = ALLB; m_first = 1;
         samp.delete();
         for (int i = 0; i < S + 2; i++) samp.push_back(ALLB);
      end else begin
         logic [7*N-1:0] cand;
         logic stable, acc;
         cand   = samp[samp.size()-2];
         stable = 1'b1;
         for (int i = 1; i <= S; i++) if (samp[samp.size()-1-i] != cand) stable = 1'b0;
         acc = stable && (cand != m_acc);
         if (m_valid && upd_ready && !acc) m_valid = 0;
         if (acc) begin
            int ndiff;
            logic ok, h, ho;
            logic [3:0] d, dold;
            if (m_valid && !upd_ready) m_over = 1;
            m_valid = 1;
            m_cnt++;
            ndiff = 0; ok = 1;
            for (int k = 0; k < N; k++) begin
               mdec(cand[7*k +: 7], h, d);
               m_blank[k] = (cand[7*k +: 7] == 7'h7F);
               m_digits[4*k +: 4] = d;
               if (!h && !m_blank[k]) m_bad = 1;
               if (cand[7*k +: 7] != m_acc[7*k +: 7]) begin
                  ndiff++;
                  mdec(m_acc[7*k +: 7], ho, dold);
                  if (!h || !ho || d != 4'(dold + 4'd1)) ok = 0;
               end
            end
            if (STEP_EN && !m_first && !(ndiff == 1 && ok)) m_step = 1;
            m_first = 0;
            m_acc = cand;
         end
         samp.push_back(hex);
         if (samp.size() > S + 2) void'(samp.pop_front());
      end
   end

   wire  [59:0] act_vec = {digits, blank, upd_valid, overrun, bad_pat, step_err, upd_cnt};
   logic [59:0] exp_vec;
   assign exp_vec = {m_digits, m_blank, m_valid, m_over, m_bad, m_step, m_cnt};

   task automatic tick();
      @(posedge clk); @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 0; hex = ALLB; upd_ready = 0;
      repeat (3) tick();
      total++;
      if (act_vec !== exp_vec || digits !== '0 || blank !== '1 || upd_cnt !== '0) begin
         bad++; $display("FAIL reset_vals act=%h exp=%h", act_vec, exp_vec);
      end
      rst_n = 1;
      for (int i = 0; i < 20; i++) begin
         tick();
         total++;
         if (upd_valid !== 1'b0 || blank !== 8'hFF || upd_cnt !== 16'd0 || act_vec !== exp_vec) begin
            bad++; $display("FAIL reset_idle cyc=%0d act=%h exp=%h", i, act_vec, exp_vec);
         end
      end
   endtask

   task automatic test_basic();
      upd_ready = 1; hex = ALLB; hex[6:0] = 7'h79;
      for (int i = 0; i < 6; i++) begin
         tick();
         total++;
         if (act_vec !== exp_vec) begin bad++; $display("FAIL basic_model cyc=%0d act=%h exp=%h", i, act_vec, exp_vec); end
         if (i == 4) begin
            total++;
            if (upd_valid !== 1'b0 || upd_cnt !== 16'd0) begin
               bad++; $display("FAIL basic_early valid=%b cnt=%0d exp 0/0", upd_valid, upd_cnt);
            end
         end
      end
      total++;
      if (digits[3:0] !== 4'd1 || blank !== 8'hFE || upd_valid !== 1'b1 || upd_cnt !== 16'd1) begin
         bad++; $display("FAIL basic_update dig=%h blank=%h valid=%b cnt=%0d exp 1/fe/1/1", digits[3:0], blank, upd_valid, upd_cnt);
      end
      tick();
      total++;
      if (upd_valid !== 1'b0) begin bad++; $display("FAIL basic_onecycle valid=%b exp 0", upd_valid); end
   endtask

   task automatic test_glitch();
      hex[6:0] = 7'h24;
      repeat (3) tick();
      hex[6:0] = 7'h79;
      for (int i = 0; i < 10; i++) begin
         tick();
         total++;
         if (act_vec !== exp_vec) begin bad++; $display("FAIL glitch_model cyc=%0d act=%h exp=%h", i, act_vec, exp_vec); end
      end
      total++;
      if (upd_cnt !== 16'd1 || upd_valid !== 1'b0) begin
         bad++; $display("FAIL glitch_ignored cnt=%0d valid=%b exp 1/0", upd_cnt, upd_valid);
      end
   endtask

   task automatic test_overrun();
      upd_ready = 0;
      hex[6:0] = 7'h24;
      repeat (8) tick();
      hex[6:0] = 7'h30;
      for (int i = 0; i < 8; i++) begin
         tick();
         total++;
         if (act_vec !== exp_vec) begin bad++; $display("FAIL overrun_model cyc=%0d act=%h exp=%h", i, act_vec, exp_vec); end
      end
      total++;
      if (upd_valid !== 1'b1 || digits[3:0] !== 4'd3 || overrun !== 1'b1) begin
         bad++; $display("FAIL overrun_flag valid=%b dig=%h ovr=%b exp 1/3/1", upd_valid, digits[3:0], overrun);
      end
      upd_ready = 1;
      tick();
      total++;
      if (upd_valid !== 1'b0 || overrun !== 1'b1) begin
         bad++; $display("FAIL overrun_drain valid=%b ovr=%b exp 0/1", upd_valid, overrun);
      end
   endtask

   task automatic test_bad_pat();
      hex[13:7] = 7'h55;
      for (int i = 0; i < 8; i++) begin
         tick();
         total++;
         if (act_vec !== exp_vec) begin bad++; $display("FAIL badpat_model cyc=%0d act=%h exp=%h", i, act_vec, exp_vec); end
      end
      total++;
      if (bad_pat !== 1'b1 || digits[7:4] !== 4'd0 || blank[1] !== 1'b0) begin
         bad++; $display("FAIL badpat_flag bad=%b dig=%h blank1=%b exp 1/0/0", bad_pat, digits[7:4], blank[1]);
      end
   endtask

   task automatic test_step();
      logic [6:0] seq [4] = '{7'h40, 7'h79, 7'h24, 7'h19};
      rst_n = 0; hex = ALLB; upd_ready = 1;
      repeat (2) tick();
      rst_n = 1;
      for (int s = 0; s < 4; s++) begin
         hex[6:0] = seq[s];
         repeat (8) tick();
         total++;
         if (act_vec !== exp_vec) begin bad++; $display("FAIL step_model s=%0d act=%h exp=%h", s, act_vec, exp_vec); end
         if (s == 2) begin
            total++;
            if (step_err !== 1'b0) begin bad++; $display("FAIL step_inc err=%b exp 0", step_err); end
         end
      end
      total++;
      if (step_err !== STEP_EN) begin bad++; $display("FAIL step_skip err=%b exp %b", step_err, STEP_EN); end
      hex[6:0] = 7'h12;
      repeat (8) tick();
      total++;
      if (step_err !== STEP_EN) begin bad++; $display("FAIL step_sticky err=%b exp %b", step_err, STEP_EN); end
      rst_n = 0; hex = ALLB;
      repeat (2) tick();
      rst_n = 1;
      hex[6:0] = 7'h40; repeat (8) tick();
      hex[6:0] = 7'h79; repeat (8) tick();
      total++;
      if (step_err !== 1'b0) begin bad++; $display("FAIL step_clear err=%b exp 0", step_err); end
      hex[6:0] = 7'h24; hex[13:7] = 7'h79;
      repeat (8) tick();
      total++;
      if (step_err !== STEP_EN || act_vec !== exp_vec) begin
         bad++; $display("FAIL step_twogrp err=%b exp %b act=%h exp=%h", step_err, STEP_EN, act_vec, exp_vec);
      end
   endtask

   task automatic test_random();
      for (int seg = 0; seg < 400; seg++) begin
         int hold;
         if (seg == 200) begin
            rst_n = 0; repeat (2) tick(); rst_n = 1;
         end
         for (int k = 0; k < N; k++) begin
            if ($urandom_range(0, 3) == 0) begin
               int r;
               r = $urandom_range(0, 19);
               if (r < 17)       hex[7*k +: 7] = TBL[$urandom_range(0, 15)];
               else if (r < 19)  hex[7*k +: 7] = 7'h7F;
               else              hex[7*k +: 7] = 7'($urandom);
            end
         end
         hold = $urandom_range(1, 7);
         for (int c = 0; c < hold; c++) begin
            upd_ready = 1'($urandom);
            tick();
            total++;
            if (act_vec !== exp_vec) begin
               bad++; $display("FAIL random seg=%0d act=%h exp=%h", seg, act_vec, exp_vec);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_glitch();
      test_overrun();
      test_bad_pat();
      test_step();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
